// File: rtl/memoria_instrucoes_pkg.sv
// Shared types and constants for the instruction memory and its byte-stream loader.
package pkg_memoria;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    TAM_ALTO  = 3'd1,
    TAM_BAIXO = 3'd2,
    DADOS     = 3'd3,
    DESCARTA  = 3'd4
  } estado_carga_t;

  localparam logic [31:0] NOP               = 32'h0000_0000;
  localparam int          BYTES_POR_PALAVRA = 4;
  localparam int          LARGURA_TAMANHO   = 16;

endpackage

// File: rtl/memoria_instrucoes_montador.sv
// Assembles four big-endian bytes into a 32-bit word; the completed word is
// presented combinationally on the strobe that carries its last byte.
module montador_palavra
  import pkg_memoria::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  byte_i,
  input  logic        strobe_i,
  input  logic        clear_i,
  output logic [31:0] palavra_o,
  output logic        completa_o
);

  localparam logic [1:0] ULTIMO = 2'(BYTES_POR_PALAVRA - 1);

  logic [23:0] parcial_q, parcial_d;
  logic [1:0]  indice_q,  indice_d;

  // Next-state for the shift register and byte index.
  always_comb begin
    parcial_d = parcial_q;
    indice_d  = indice_q;
    if (clear_i) begin
      parcial_d = 24'h00_0000;
      indice_d  = 2'd0;
    end else if (strobe_i) begin
      parcial_d = {parcial_q[15:0], byte_i};
      indice_d  = indice_q + 2'd1;
    end else begin
      parcial_d = parcial_q;
      indice_d  = indice_q;
    end
  end

  // Shift register and index state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parcial_q <= 24'h00_0000;
      indice_q  <= 2'd0;
    end else begin
      parcial_q <= parcial_d;
      indice_q  <= indice_d;
    end
  end

  assign palavra_o  = {parcial_q, byte_i};
  assign completa_o = strobe_i && !clear_i && (indice_q == ULTIMO);

endmodule

// File: rtl/memoria_instrucoes.sv
// Word-addressed instruction memory with a registered read port and a
// byte-stream loader (16-bit big-endian word count followed by the words).
module memoria_instrucoes
  import pkg_memoria::*;
#(
  parameter int PALAVRAS    = 256,
  parameter int LARGURA_END = $clog2(PALAVRAS)
) (
  input  logic        clock,
  input  logic        reseta,
  input  logic [31:0] endereco,
  output logic [31:0] instrucao,
  input  logic        carga_inicio,
  input  logic        carga_valido,
  input  logic [7:0]  carga_byte,
  output logic        carga_pronto,
  output logic        ocupado,
  output logic        carga_concluida,
  output logic        erro
);

  localparam int                         LARGURA_CONT = LARGURA_END + 1;
  localparam logic [31:0]                LIMITE_END   = 32'(PALAVRAS);
  localparam logic [LARGURA_TAMANHO-1:0] LIMITE_TAM   = LARGURA_TAMANHO'(PALAVRAS);

  logic [31:0] mem [PALAVRAS];

  estado_carga_t               estado_q, estado_d;
  logic [LARGURA_TAMANHO-1:0]  tam_q, tam_d, tam_novo;
  logic [LARGURA_CONT-1:0]     cont_q, cont_d, cont_inc;
  logic                        erro_q, erro_d;
  logic                        concl_q, concl_d;
  logic [31:0]                 instr_q;

  logic        aceita;
  logic        escreve;
  logic        mont_strobe;
  logic        mont_clear;
  logic        mont_completa;
  logic [31:0] mont_palavra;

  assign ocupado      = (estado_q != OCIOSO);
  assign carga_pronto = ocupado && !carga_inicio;
  assign aceita       = carga_valido && carga_pronto;
  assign cont_inc     = cont_q + 1'b1;
  assign tam_novo     = {tam_q[15:8], carga_byte};

  montador_palavra u_montador (
    .clk_i      (clock),
    .rst_ni     (reseta),
    .byte_i     (carga_byte),
    .strobe_i   (mont_strobe),
    .clear_i    (mont_clear),
    .palavra_o  (mont_palavra),
    .completa_o (mont_completa)
  );

  // Loader FSM: next state, size/counter bookkeeping and write enable.
  always_comb begin
    estado_d    = estado_q;
    tam_d       = tam_q;
    cont_d      = cont_q;
    erro_d      = erro_q;
    concl_d     = 1'b0;
    escreve     = 1'b0;
    mont_strobe = 1'b0;
    mont_clear  = 1'b0;
    if (carga_inicio) begin
      // A start pulse restarts from any state; a byte in this cycle is ignored.
      estado_d   = TAM_ALTO;
      tam_d      = '0;
      cont_d     = '0;
      erro_d     = 1'b0;
      mont_clear = 1'b1;
    end else begin
      case (estado_q)
        OCIOSO: begin
          estado_d = OCIOSO;
        end
        TAM_ALTO: begin
          if (aceita) begin
            tam_d    = {carga_byte, 8'h00};
            estado_d = TAM_BAIXO;
          end else begin
            estado_d = TAM_ALTO;
          end
        end
        TAM_BAIXO: begin
          if (aceita) begin
            tam_d = tam_novo;
            if (tam_novo == '0) begin
              estado_d = OCIOSO;
              concl_d  = 1'b1;
            end else if (tam_novo > LIMITE_TAM) begin
              estado_d = DESCARTA;
              erro_d   = 1'b1;
            end else begin
              estado_d   = DADOS;
              cont_d     = '0;
              mont_clear = 1'b1;
            end
          end else begin
            estado_d = TAM_BAIXO;
          end
        end
        DADOS: begin
          mont_strobe = aceita;
          if (mont_completa) begin
            escreve = 1'b1;
            cont_d  = cont_inc;
            if (LARGURA_TAMANHO'(cont_inc) == tam_q) begin
              estado_d = OCIOSO;
              concl_d  = 1'b1;
            end else begin
              estado_d = DADOS;
            end
          end else begin
            estado_d = DADOS;
          end
        end
        DESCARTA: begin
          estado_d = DESCARTA;
        end
        default: begin
          estado_d = OCIOSO;
        end
      endcase
    end
  end

  // Loader state registers.
  always_ff @(posedge clock or negedge reseta) begin
    if (!reseta) begin
      estado_q <= OCIOSO;
      tam_q    <= '0;
      cont_q   <= '0;
      erro_q   <= 1'b0;
      concl_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      tam_q    <= tam_d;
      cont_q   <= cont_d;
      erro_q   <= erro_d;
      concl_q  <= concl_d;
    end
  end

  // Write port; contents survive reset so completed words of an aborted load remain.
  always_ff @(posedge clock) begin
    if (escreve) begin
      mem[cont_q[LARGURA_END-1:0]] <= mont_palavra;
    end
  end

  // Registered read port; NOP while loading or for out-of-range addresses.
  always_ff @(posedge clock or negedge reseta) begin
    if (!reseta) begin
      instr_q <= NOP;
    end else if (ocupado || (endereco >= LIMITE_END)) begin
      instr_q <= NOP;
    end else begin
      instr_q <= mem[endereco[LARGURA_END-1:0]];
    end
  end

  assign instrucao       = instr_q;
  assign erro            = erro_q;
  assign carga_concluida = concl_q;

endmodule

// File: tb/tb_memoria_instrucoes.sv
// Randomised self-checking bench for memoria_instrucoes against a stream-level
// reference model of the memory contents.
module tb_memoria_instrucoes;

  localparam int PALAVRAS = 256;

  logic        clock = 1'b0;
  logic        reseta = 1'b0;
  logic [31:0] endereco = 32'h0;
  logic [31:0] instrucao;
  logic        carga_inicio = 1'b0;
  logic        carga_valido = 1'b0;
  logic [7:0]  carga_byte = 8'h00;
  logic        carga_pronto;
  logic        ocupado;
  logic        carga_concluida;
  logic        erro;

  int compared   = 0;
  int mismatched = 0;
  int concl_count = 0;

  logic [31:0] mem_model [PALAVRAS];
  logic        last_concl, last_ocup;

  memoria_instrucoes #(.PALAVRAS(PALAVRAS)) dut (
    .clock           (clock),
    .reseta          (reseta),
    .endereco        (endereco),
    .instrucao       (instrucao),
    .carga_inicio    (carga_inicio),
    .carga_valido    (carga_valido),
    .carga_byte      (carga_byte),
    .carga_pronto    (carga_pronto),
    .ocupado         (ocupado),
    .carga_concluida (carga_concluida),
    .erro            (erro)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (carga_concluida === 1'b1) concl_count++;
  end

  // Apply a byte stream to the model: only fully received words of a valid size land.
  function automatic void model_apply(input logic [7:0] s[$]);
    int n;
    if (s.size() < 2) return;
    n = {s[0], s[1]};
    if (n == 0 || n > PALAVRAS) return;
    for (int i = 0; i < n; i++) begin
      if (2 + 4*i + 3 < s.size())
        mem_model[i] = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_load(input logic [7:0] s[$], input bit start, input int max_gap);
    if (start) begin
      carga_inicio = 1'b1;
      @(negedge clock);
      carga_inicio = 1'b0;
    end
    foreach (s[i]) begin
      repeat ($urandom_range(max_gap, 0)) @(negedge clock);
      carga_valido = 1'b1;
      carga_byte   = s[i];
      @(negedge clock);
      carga_valido = 1'b0;
      carga_byte   = 8'($urandom);
    end
    last_concl = carga_concluida;
    last_ocup  = ocupado;
  endtask

  task automatic read_word(input logic [31:0] addr, output logic [31:0] v);
    endereco = addr;
    @(negedge clock);
    v = instrucao;
  endtask

  task automatic test_reset;
    reseta = 1'b0;
    idle(2);
    compared++;
    if (instrucao !== 32'h0 || ocupado !== 1'b0 || carga_pronto !== 1'b0 ||
        erro !== 1'b0 || carga_concluida !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_held: instr=%h ocup=%b pronto=%b erro=%b concl=%b, want all 0",
               instrucao, ocupado, carga_pronto, erro, carga_concluida);
    end
    reseta = 1'b1;
    idle(2);
    compared++;
    if (instrucao !== 32'h0 || ocupado !== 1'b0 || carga_pronto !== 1'b0 || erro !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_released: instr=%h ocup=%b pronto=%b erro=%b, want all 0",
               instrucao, ocupado, carga_pronto, erro);
    end
  endtask

  task automatic test_full_load;
    logic [7:0]  s[$];
    logic [31:0] v;
    int          a;
    s.push_back(8'h01);
    s.push_back(8'h00);
    for (int i = 0; i < 4*PALAVRAS; i++) s.push_back(8'($urandom));
    send_load(s, 1'b1, 1);
    model_apply(s);
    compared++;
    if (last_concl !== 1'b1 || last_ocup !== 1'b0) begin
      mismatched++;
      $display("FAIL full_load_done: concl=%b ocup=%b, want 1/0", last_concl, last_ocup);
    end
    for (int k = 0; k < 18; k++) begin
      a = (k == 0) ? 0 : (k == 1) ? PALAVRAS-1 : int'($urandom_range(PALAVRAS-1, 0));
      read_word(32'(a), v);
      compared++;
      if (v !== mem_model[a]) begin
        mismatched++;
        $display("FAIL full_load_read[%0d]: got %h want %h", a, v, mem_model[a]);
      end
    end
  endtask

  task automatic test_normal_load;
    logic [7:0]  s[$];
    logic [31:0] v;
    int          c0;
    s  = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    c0 = concl_count;
    send_load(s, 1'b1, 0);
    model_apply(s);
    compared++;
    if (last_concl !== 1'b1 || last_ocup !== 1'b0) begin
      mismatched++;
      $display("FAIL normal_done: concl=%b ocup=%b, want 1/0", last_concl, last_ocup);
    end
    for (int a = 0; a < 3; a++) begin
      read_word(32'(a), v);
      compared++;
      if (v !== mem_model[a]) begin
        mismatched++;
        $display("FAIL normal_read[%0d]: got %h want %h", a, v, mem_model[a]);
      end
    end
    compared++;
    if (concl_count - c0 !== 1) begin
      mismatched++;
      $display("FAIL normal_pulses: got %0d pulses want 1", concl_count - c0);
    end
  endtask

  task automatic test_empty_load;
    logic [7:0]  s[$];
    logic [31:0] v;
    s = '{8'h00, 8'h00};
    send_load(s, 1'b1, 2);
    compared++;
    if (last_concl !== 1'b1 || last_ocup !== 1'b0) begin
      mismatched++;
      $display("FAIL empty_done: concl=%b ocup=%b, want 1/0", last_concl, last_ocup);
    end
    for (int a = 0; a < 2; a++) begin
      read_word(32'(a), v);
      compared++;
      if (v !== mem_model[a]) begin
        mismatched++;
        $display("FAIL empty_read[%0d]: got %h want %h", a, v, mem_model[a]);
      end
    end
  endtask

  task automatic test_oversize;
    logic [7:0]  s[$];
    logic [31:0] v;
    int          c0;
    c0 = concl_count;
    s  = '{8'h01, 8'h01};
    send_load(s, 1'b1, 1);
    compared++;
    if (erro !== 1'b1 || ocupado !== 1'b1 || last_concl !== 1'b0) begin
      mismatched++;
      $display("FAIL oversize_flag: erro=%b ocup=%b concl=%b, want 1/1/0", erro, ocupado, last_concl);
    end
    read_word(32'h0, v);
    compared++;
    if (v !== 32'h0) begin
      mismatched++;
      $display("FAIL oversize_read_busy: got %h want 00000000", v);
    end
    s = {};
    for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
    send_load(s, 1'b0, 1);
    compared++;
    if (erro !== 1'b1 || ocupado !== 1'b1 || carga_pronto !== 1'b1) begin
      mismatched++;
      $display("FAIL oversize_discard: erro=%b ocup=%b pronto=%b, want 1/1/1", erro, ocupado, carga_pronto);
    end
    carga_inicio = 1'b1;
    #1;
    compared++;
    if (carga_pronto !== 1'b0) begin
      mismatched++;
      $display("FAIL pronto_on_inicio: got %b want 0", carga_pronto);
    end
    @(negedge clock);
    carga_inicio = 1'b0;
    compared++;
    if (erro !== 1'b0 || ocupado !== 1'b1) begin
      mismatched++;
      $display("FAIL oversize_restart: erro=%b ocup=%b, want 0/1", erro, ocupado);
    end
    s = '{8'h00, 8'h00};
    send_load(s, 1'b0, 0);
    idle(2);
    compared++;
    if (concl_count - c0 !== 1) begin
      mismatched++;
      $display("FAIL oversize_pulses: got %0d want 1", concl_count - c0);
    end
    for (int a = 0; a < 4; a++) begin
      read_word(32'(a), v);
      compared++;
      if (v !== mem_model[a]) begin
        mismatched++;
        $display("FAIL oversize_mem[%0d]: got %h want %h", a, v, mem_model[a]);
      end
    end
  endtask

  task automatic test_reset_mid_load;
    logic [7:0]  s[$];
    logic [31:0] v;
    int          c0;
    c0 = concl_count;
    s  = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE};
    send_load(s, 1'b1, 1);
    reseta = 1'b0;
    @(negedge clock);
    compared++;
    if (ocupado !== 1'b0 || carga_pronto !== 1'b0 || carga_concluida !== 1'b0) begin
      mismatched++;
      $display("FAIL midload_reset: ocup=%b pronto=%b concl=%b, want 0/0/0",
               ocupado, carga_pronto, carga_concluida);
    end
    reseta = 1'b1;
    idle(2);
    compared++;
    if (concl_count !== c0) begin
      mismatched++;
      $display("FAIL midload_pulses: got %0d want 0", concl_count - c0);
    end
    read_word(32'h0, v);
    compared++;
    if (v !== mem_model[0]) begin
      mismatched++;
      $display("FAIL midload_mem0: got %h want %h", v, mem_model[0]);
    end
  endtask

  task automatic test_restart_mid_data;
    logic [7:0]  s[$];
    logic [31:0] v;
    s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_load(s, 1'b1, 1);
    model_apply(s);
    s = '{8'h00, 8'h00};
    send_load(s, 1'b1, 0);
    compared++;
    if (last_concl !== 1'b1) begin
      mismatched++;
      $display("FAIL restart_done: concl=%b want 1", last_concl);
    end
    for (int a = 0; a < 3; a++) begin
      read_word(32'(a), v);
      compared++;
      if (v !== mem_model[a]) begin
        mismatched++;
        $display("FAIL restart_mem[%0d]: got %h want %h", a, v, mem_model[a]);
      end
    end
  endtask

  task automatic test_boundaries;
    logic [7:0]  s[$];
    logic [31:0] v;
    logic [31:0] addrs [3];
    addrs = '{32'd256, 32'h8000_0000, 32'hFFFF_FFFF};
    foreach (addrs[i]) begin
      read_word(addrs[i], v);
      compared++;
      if (v !== 32'h0) begin
        mismatched++;
        $display("FAIL out_of_range[%h]: got %h want 00000000", addrs[i], v);
      end
    end
    carga_inicio = 1'b1;
    carga_valido = 1'b1;
    carga_byte   = 8'hFF;
    @(negedge clock);
    carga_inicio = 1'b0;
    carga_valido = 1'b0;
    s = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_load(s, 1'b0, 3);
    model_apply(s);
    compared++;
    if (last_concl !== 1'b1 || erro !== 1'b0) begin
      mismatched++;
      $display("FAIL inicio_with_byte: concl=%b erro=%b, want 1/0", last_concl, erro);
    end
    read_word(32'h0, v);
    compared++;
    if (v !== mem_model[0]) begin
      mismatched++;
      $display("FAIL inicio_with_byte_mem0: got %h want %h", v, mem_model[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  s[$];
    logic [31:0] v;
    int          n, a;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(12, 1));
      s = {};
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      for (int i = 0; i < 4*n; i++) s.push_back(8'($urandom));
      send_load(s, 1'b1, (it % 2 == 0) ? 0 : 4);
      model_apply(s);
      compared++;
      if (last_concl !== 1'b1 || last_ocup !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_done[%0d]: concl=%b ocup=%b, want 1/0", it, last_concl, last_ocup);
      end
      for (int k = 0; k < 4; k++) begin
        a = (k == 0) ? n - 1 : int'($urandom_range(15, 0));
        read_word(32'(a), v);
        compared++;
        if (v !== mem_model[a]) begin
          mismatched++;
          $display("FAIL b2b_read[%0d][%0d]: got %h want %h", it, a, v, mem_model[a]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_normal_load();
    test_empty_load();
    test_oversize();
    test_reset_mid_load();
    test_restart_mid_data();
    test_boundaries();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/memoria_instrucoes.md
# memoria_instrucoes

Word-addressed instruction memory that answers the program counter's fetch address with a registered 32-bit instruction, plus a byte-stream loader that writes a program into the memory at run time. It sits between the PC, which supplies `endereco` and increments by 1 per instruction, and the instruction decoder. It is fed by a byte source such as a UART receiver. While a load is in progress it raises `ocupado`; the top level uses this to hold the processor in reset.

## Interface
- `PALAVRAS`, 256: memory depth in 32-bit words.
- `LARGURA_END`, `$clog2(PALAVRAS)`: internal index width.
- `clock` in 1: single clock, rising edge.
- `reseta` in 1: asynchronous, active-low reset.
- `endereco` in 32: word address from the PC.
- `instrucao` out 32: registered instruction for `endereco`.
- `carga_inicio` in 1: single-cycle pulse that starts or restarts a load.
- `carga_valido` in 1: byte strobe; a byte transfers when `carga_valido && carga_pronto`.
- `carga_byte` in 8: load data byte.
- `carga_pronto` out 1: loader accepts a byte this cycle.
- `ocupado` out 1: load in progress; the processor must be held.
- `carga_concluida` out 1: one-cycle pulse when a load finishes successfully.
- `erro` out 1: the declared size exceeds `PALAVRAS`; sticky until the next `carga_inicio` or reset.

## Operation
- Load stream format:
  - Byte 0 and byte 1 form the word count N, big-endian, 16 bits.
  - Then N words follow, 4 bytes each, big-endian.
  - Words are written to addresses 0..N-1.
- States: OCIOSO, TAM_ALTO, TAM_BAIXO, DADOS, DESCARTA.
- Transitions:
  - OCIOSO → TAM_ALTO on `carga_inicio`.
  - TAM_ALTO → TAM_BAIXO on an accepted byte, which is stored as N[15:8].
  - TAM_BAIXO, on an accepted byte (N[7:0]):
    - N==0: → OCIOSO and pulse `carga_concluida`.
    - N>PALAVRAS: → DESCARTA and set `erro`.
    - Otherwise: → DADOS with word counter = 0 and byte index = 0.
  - DADOS: each accepted byte shifts into the assembly register. On the 4th byte, the full word is written to mem[counter] and the counter increments. When the written word is number N, the FSM goes → OCIOSO and pulses `carga_concluida`.
  - DESCARTA: all bytes are accepted and dropped. The FSM stays there until `carga_inicio`.
- `carga_inicio` in any state other than OCIOSO restarts the load at TAM_ALTO. It clears `erro`, the counter and the byte index. A byte presented in the same cycle is ignored.
- Output equations:
  - `carga_pronto` = (state != OCIOSO) && !`carga_inicio`.
  - `ocupado` = state != OCIOSO.
- Bytes presented while `carga_pronto` is low are dropped, with no back-pressure beyond `carga_pronto`. Idle cycles between bytes are allowed.
- Read path, each rising edge:
  - `instrucao` <= 0 (NOP) if `ocupado` or `endereco` >= `PALAVRAS`.
  - Otherwise `instrucao` <= mem[`endereco`[LARGURA_END-1:0]].
- Memory contents are not cleared by reset. At power-up (initial) they are all 0. A load overwrites only addresses 0..N-1; other words are kept.

## Timing
- Reset values:
  - state OCIOSO, `instrucao` 0, `carga_pronto` 0, `ocupado` 0, `carga_concluida` 0, `erro` 0.
  - Counter, byte index and N are 0.
- Read latency: 1 cycle, from `endereco` valid at edge k to `instrucao` valid after edge k+1.
- Write commit: the word is in memory on the edge that accepts its 4th byte, so a read of it may start the next cycle.
- `carga_concluida` is high for exactly the cycle after the final accepted byte. `ocupado` falls on that same edge.
- `erro` rises on the edge that accepts N[7:0].
- Reset during a load aborts it immediately:
  - Words already completed stay written.
  - A partially assembled word is discarded.
  - No `carga_concluida` pulse is produced.
- Minimum load time is 2 + 4N accepted bytes, one byte per cycle maximum.

## Structure
- Shared package `pkg_memoria` holds:
  - State enum `estado_carga_t`.
  - `NOP = 32'h0000_0000`.
  - `BYTES_POR_PALAVRA = 4`.
  - `LARGURA_TAMANHO = 16`.
- One natural sub-module, `montador_palavra`:
  - Inputs: byte, strobe, clear.
  - Behaviour: 4-byte big-endian shift register with a 2-bit index.
  - Outputs: `palavra`, and a `completa` pulse on the 4th byte.
- The FSM, counter and memory array live in `memoria_instrucoes`. The array is inferred as block RAM: one synchronous write port and one synchronous read port.

## Test plan
- **Reset:** hold `reseta`=0 then release. Expect `instrucao`=0, `ocupado`=0, `carga_pronto`=0, `erro`=0.
- **Normal load:** pulse `carga_inicio`, then send 00 02 DE AD BE EF 01 23 45 67.
  - `carga_concluida` pulses once after the 10th byte and `ocupado` falls on the same edge.
  - `endereco`=0 gives `instrucao`=DEADBEEF, and `endereco`=1 gives 01234567, each one cycle later.
- **Empty load:** send 00 00. Expect `carga_concluida` after the 2nd byte; words 0..1 from the previous load are unchanged.
- **Oversize:** with `PALAVRAS`=256, send 01 01. Expect `erro`=1 and `ocupado`=1.
  - 8 further bytes are dropped and memory is unchanged.
  - `carga_inicio` clears `erro`.
- **Reset mid-load:** after 00 02 DE AD BE, assert `reseta`=0. Expect state OCIOSO, no `carga_concluida`, and address 0 still holding its old word.
- **Boundaries:**
  - `endereco`=256 gives `instrucao`=0.
  - `carga_inicio` and `carga_valido` in the same cycle: the byte is ignored.
  - Random idle gaps between bytes still produce a correct load.
